// File: rtl/score_digits_display.sv
// Score renderer for the VGA overlay: binary score -> BCD digits by sequential
// double-dabble, drawn from an external 10-glyph ROM at a fixed screen position.
// New digits are committed only while the scan is outside the text band.
module score_digits_display #(
    parameter int         NUM_DIGITS = 4,
    parameter int         SCORE_W    = 14,
    parameter int         START_X    = 332,
    parameter int         START_Y    = 427,
    parameter int         DIGIT_W    = 16,
    parameter int         DIGIT_H    = 32,
    parameter int         GAP        = 4,
    parameter bit         LZ_BLANK   = 1'b1,
    parameter logic [2:0] FG_RGB     = 3'b001,
    parameter logic [2:0] BG_RGB     = 3'b000,
    parameter int         GA_W       = 13
) (
    input  logic               iVGA_CLK,
    input  logic               iRST_n,
    input  logic [9:0]         iVGA_X,
    input  logic [9:0]         iVGA_Y,
    input  logic [SCORE_W-1:0] iScore,
    input  logic               iScore_Valid,
    output logic               oBusy,
    output logic [GA_W-1:0]    oGlyph_Addr,
    input  logic               iGlyph_Pixel,
    output logic               oActive,
    output logic [2:0]         oRGB
);

    localparam int     BW       = 4 * NUM_DIGITS;
    localparam int     PITCH    = DIGIT_W + GAP;
    localparam int     CELL_PIX = DIGIT_W * DIGIT_H;
    localparam longint LIMIT    = 10 ** NUM_DIGITS;
    localparam int     CNT_W    = $clog2(SCORE_W + 1);
    localparam int     CW       = (DIGIT_W > 1) ? $clog2(DIGIT_W) : 1;
    localparam int     RW       = (DIGIT_H > 1) ? $clog2(DIGIT_H) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_WAIT_SAFE,
        S_COMMIT
    } state_t;

    // Scores that do not fit in NUM_DIGITS decimal digits show as all nines.
    function automatic logic [SCORE_W-1:0] saturate(input logic [SCORE_W-1:0] v);
        if (64'(v) >= LIMIT) saturate = SCORE_W'(LIMIT - 1);
        else                 saturate = v;
    endfunction

    // ---------------- conversion / commit control ----------------
    state_t               state_q, state_d;
    logic [SCORE_W-1:0]   bin_q, bin_d;
    logic [BW-1:0]        bcd_q, bcd_d;
    logic [BW-1:0]        bcd_adj;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic [SCORE_W-1:0]   pend_val_q, pend_val_d;
    logic [BW-1:0]        shown_q, shown_d;   // digit k (0 = MSD) at [BW-1-4k -: 4]
    logic [10:0]          x11, y11;
    logic                 band_safe;

    assign x11       = {1'b0, iVGA_X};
    assign y11       = {1'b0, iVGA_Y};
    assign band_safe = (y11 < 11'(START_Y)) || (y11 >= 11'(START_Y + DIGIT_H));

    // Next-state logic for capture, double-dabble steps, safe wait and commit.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        shown_d    = shown_q;

        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end

        case (state_q)
            S_IDLE: begin
                // A fresh strobe beats an older pending value.
                if (iScore_Valid) begin
                    bin_d   = saturate(iScore);
                    bcd_d   = '0;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    state_d = S_CONVERT;
                end else if (pend_q) begin
                    bin_d   = saturate(pend_val_q);
                    bcd_d   = '0;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                {bcd_d, bin_d} = {bcd_adj[BW-2:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SCORE_W - 1)) state_d = S_WAIT_SAFE;
            end
            S_WAIT_SAFE: begin
                if (band_safe) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                shown_d = bcd_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes arriving while busy are parked; the last one wins.
        if (state_q != S_IDLE && iScore_Valid) begin
            pend_d     = 1'b1;
            pend_val_d = iScore;
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge iVGA_CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!iRST_n) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            // NOTE: the shown digits are reset because they feed visible pixels straight away.
            shown_q    <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            shown_q    <= shown_d;
        end
    end

    assign oBusy = (state_q != S_IDLE);

    // ---------------- pixel pipeline ----------------
    logic [NUM_DIGITS-1:0] blank_vec;
    logic                  zero_run;

    // Leading-zero blanking: a digit blanks when it and every digit left of it are zero.
    always_comb begin
        zero_run  = 1'b1;
        blank_vec = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            zero_run     = zero_run && (shown_q[BW-1-4*k -: 4] == 4'd0);
            blank_vec[k] = LZ_BLANK && zero_run && (k < NUM_DIGITS - 1);
        end
    end

    logic            in_band_c, hit_c, blank_c;
    logic [CW-1:0]   col_c;
    logic [RW-1:0]   row_c;
    logic [3:0]      dig_c;
    logic [GA_W-1:0] addr_c;

    // Stage-1 decode: which cell the scan position hits and the glyph address within it.
    always_comb begin
        in_band_c = (y11 >= 11'(START_Y)) && (y11 < 11'(START_Y + DIGIT_H));
        row_c     = RW'(y11 - 11'(START_Y));
        hit_c     = 1'b0;
        blank_c   = 1'b0;
        col_c     = '0;
        dig_c     = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (in_band_c && (x11 >= 11'(START_X + k*PITCH)) &&
                (x11 < 11'(START_X + k*PITCH + DIGIT_W))) begin
                hit_c   = 1'b1;
                col_c   = CW'(x11 - 11'(START_X + k*PITCH));
                dig_c   = shown_q[BW-1-4*k -: 4];
                blank_c = blank_vec[k];
            end
        end
        addr_c = '0;
        if (hit_c) begin
            addr_c = GA_W'(dig_c) * GA_W'(CELL_PIX) + GA_W'(row_c) * GA_W'(DIGIT_W) + GA_W'(col_c);
        end
    end

    logic [GA_W-1:0] addr_q;
    logic            hit1_q, blank1_q, hit2_q, blank2_q;
    logic            active_q;
    logic [2:0]      rgb_q;

    // Three-stage pipeline: address out, ROM read, colour out; flags travel alongside.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            addr_q   <= '0;
            hit1_q   <= 1'b0;
            blank1_q <= 1'b0;
            hit2_q   <= 1'b0;
            blank2_q <= 1'b0;
            active_q <= 1'b0;
            rgb_q    <= BG_RGB;
        end else begin
            addr_q   <= addr_c;
            hit1_q   <= hit_c;
            blank1_q <= blank_c;
            hit2_q   <= hit1_q;
            blank2_q <= blank1_q;
            active_q <= hit2_q;
            rgb_q    <= (hit2_q && !blank2_q && iGlyph_Pixel) ? FG_RGB : BG_RGB;
        end
    end

    assign oGlyph_Addr = addr_q;
    assign oActive     = active_q;
    assign oRGB        = rgb_q;

endmodule
